// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential fetch from instruction memory into an
// in-order prefetch FIFO, with redirect flush on taken branches/jumps.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [31:0]              if_pc,
    output logic [31:0]              if_instr,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;

    // Request is suppressed by reset, a redirect, or a full buffer; no pop bypass.
    assign w_full    = (r_count == CW'(DEPTH));
    assign imem_req  = !reset && !redirect_valid && !w_full;
    assign imem_addr = r_fetch_pc;

    assign w_push = imem_req && imem_ack;
    assign w_pop  = (r_count != '0) && if_ready && !redirect_valid;

    assign if_valid   = (r_count != '0);
    assign fifo_count = r_count;
    assign if_pc      = if_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
    assign if_instr   = if_valid ? r_instr_mem[r_rd_ptr] : 32'h0;

    // Fetch address, occupancy and pointers; redirect overrides push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_wr_ptr   <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [$clog2(DEPTH):0] fifo_count;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: buffered {pc, instr} pairs and the next fetch address.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        e_req   = !reset && !redirect_valid && (m_q.size() < DEPTH);
        e_valid = (m_q.size() != 0);
        e_pc    = e_valid ? m_q[0][63:32] : 32'h0;
        e_instr = e_valid ? m_q[0][31:0]  : 32'h0;
        check("imem_req",   32'(imem_req),   32'(e_req));
        check("imem_addr",  imem_addr,       m_pc);
        check("if_valid",   32'(if_valid),   32'(e_valid));
        check("if_pc",      if_pc,           e_pc);
        check("if_instr",   if_instr,        e_instr);
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    endtask

    // One clock cycle: drive at negedge, check, then advance the model at posedge.
    task automatic step(input logic ack, input logic rdy, input logic redir, input logic [31:0] rpc);
        logic e_req;
        logic e_valid;
        imem_ack       = ack;
        if_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rdata     = ack ? mem_word(m_pc) : $urandom;
        #1;
        check_outputs();
        e_req   = !redir && (m_q.size() < DEPTH);
        e_valid = (m_q.size() != 0);
        @(posedge clk);
        if (redir) begin
            m_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (e_valid && rdy) void'(m_q.pop_front());
            if (e_req && ack) begin
                m_q.push_back({m_pc, imem_rdata});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; state must clear before any edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_q.delete();
        m_pc = RESET_PC;
        check("rst_imem_req",   32'(imem_req),   32'h0);
        check("rst_if_valid",   32'(if_valid),   32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        check("rst_if_pc",      if_pc,           32'h0);
        check("rst_if_instr",   if_instr,        32'h0);
        check("rst_imem_addr",  imem_addr,       RESET_PC);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        m_pc = RESET_PC;
        @(negedge clk);
        do_reset();

        // Free-running: one instruction per cycle, occupancy never above 1.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check("stream_if_pc", if_pc, 32'h1C);
        check("stream_count", 32'(fifo_count), 32'h1);

        // Fill to full with a stalled consumer, then drain in order.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        check("full_req",   32'(imem_req),   32'h0);
        check("full_addr",  imem_addr,       32'h10);
        check("full_if_pc", if_pc,           32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Memory wait states at address 0x8.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wait_addr",  imem_addr,       32'h8);
        check("wait_count", 32'(fifo_count), 32'h2);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("wait_push_count", 32'(fifo_count), 32'h3);

        // Redirect with concurrent ack and ready, unaligned target.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        check("redir_count", 32'(fifo_count), 32'h0);
        check("redir_addr",  imem_addr,       32'h100);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_if_pc", if_pc, 32'h100);
        step(1'b1, 1'b1, 1'b0, 32'h0);

        // Address wrap past the top of memory.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Back-to-back redirects: only the last target is ever presented.
        step(1'b1, 1'b0, 1'b1, 32'h0000_2000);
        step(1'b1, 1'b0, 1'b1, 32'h0000_3004);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Reset while two entries are buffered and a request is pending.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        imem_ack = 1'b1;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0,
                 ($urandom % 16) == 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
